wb_cmd_master: RTL
==================

// Module: wb_cmd_master
// PURPOSE
//  Single-outstanding WISHBONE classic-cycle master: turns a valid/ready command port into bus cycles.
//  Retries on RTY_I, aborts on ERR_I or timeout, and returns one status/data response per command.
//  Used by DMA/debug/host-side logic to reach WISHBONE slaves (incl. bus_terminator-covered ranges).
// PARAMETERS
//  TIMEOUT    255  cycles CYC_O may stay high per attempt without ACK/ERR/RTY (1..65535)
//  MAX_RETRY  3    RTY_I terminations retried before giving up (0..15; 0 = no retry)
//  RETRY_GAP  2    idle cycles with CYC_O=0 between an RTY_I and the next attempt (0..15)
// PORTS
//  CLK_I         in   1   clock, all logic rising-edge
//  reset_n       in   1   asynchronous, active-low reset
//  req_valid     in   1   command present
//  req_ready     out  1   command accepted when req_valid&&req_ready
//  req_we        in   1   1=write, 0=read
//  req_adr       in   30  word address [31:2]
//  req_sel       in   4   byte lanes
//  req_data      in   32  write data
//  resp_valid    out  1   one-cycle response pulse, no backpressure
//  resp_status   out  2   00 OK, 01 ERR, 10 RTY exhausted, 11 timeout
//  resp_data     out  32  read data (0 for writes / non-OK)
//  CYC_O,STB_O   out  1   bus cycle / strobe (always equal)
//  WE_O          out  1   write enable
//  ADR_O         out  30  [31:2] address
//  SEL_O         out  4   byte select
//  master_DAT_O  out  32  write data
//  master_DAT_I  in   32  read data
//  ACK_I,ERR_I,RTY_I in 1 slave terminations
// BEHAVIOUR
//  - Reset (async, immediate, incl. mid-cycle): state IDLE, all outputs 0 except req_ready=1; counters 0.
//  - All outputs registered. States: IDLE, BUS, GAP, RESP.
//  - IDLE: req_ready=1. On accept at edge E: latch we/adr/sel/data; CYC_O=STB_O=1 from cycle after E (BUS).
//  - ADR_O/SEL_O/WE_O/master_DAT_O hold latched values for whole command incl. retries; 0 in IDLE.
//  - BUS: each cycle sample terminations, priority ERR_I > ACK_I > RTY_I.
//    ACK_I: next cycle CYC_O=0, RESP, status 00, resp_data=master_DAT_I sampled on ACK edge if read.
//    ERR_I: next cycle CYC_O=0, RESP, status 01.
//    RTY_I: retry_cnt==MAX_RETRY -> RESP status 10; else retry_cnt++, CYC_O=0,
//    GAP for RETRY_GAP cycles (0 -> CYC_O low exactly 1 cycle), then BUS again.
//    none: tmo_cnt++; if tmo_cnt==TIMEOUT-1 -> RESP status 11. CYC_O high exactly TIMEOUT cycles.
//  - Termination on the final timeout cycle wins over timeout.
//  - tmo_cnt cleared at start of every attempt; retry_cnt cleared on accept.
//  - RESP: resp_valid=1 exactly one cycle, CYC_O=0, req_ready=0; next cycle IDLE (req_ready=1).
//    resp_status/resp_data hold until next response; resp_data=0 unless read with status 00.
//  - Min command: accept E, CYC high E+1, ACK at E+1 -> resp_valid E+2, req_ready E+3.
//  - Terminations outside BUS ignored; req_valid while busy ignored (req_ready=0).
// TESTING
//  - Read 0x00F00010, slave ACKs 1st cycle, DAT=0xDEADBEEF -> CYC 1 cycle, resp 00/0xDEADBEEF 1 cycle later.
//  - Write SEL=4'b0011 data 0x12345678, ACK after 3 wait cycles -> DAT_O/SEL stable 4 cycles, resp 00, data 0.
//  - RTY on every attempt, MAX_RETRY=3 -> 4 CYC pulses, 2-cycle gaps, resp status 10.
//  - RTY twice then ACK -> 3 attempts, status 00; ACK+RTY same cycle -> ACK taken, status 00.
//  - No response, TIMEOUT=8 -> CYC high exactly 8 cycles, status 11; ERR+ACK same cycle -> status 01.
//  - reset_n low during BUS -> CYC_O/STB_O 0 immediately, no resp_valid; next command works normally.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Single-outstanding WISHBONE classic-cycle master driven by a valid/ready command port.
// Retries on RTY_I, aborts on ERR_I or per-attempt timeout, and returns one response per command.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned RETRY_GAP = 2
) (
    input  logic        CLK_I,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [29:0] req_adr,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_data,
    output logic        resp_valid,
    output logic [1:0]  resp_status,
    output logic [31:0] resp_data,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [29:0] ADR_O,
    output logic [3:0]  SEL_O,
    output logic [31:0] master_DAT_O,
    input  logic [31:0] master_DAT_I,
    input  logic        ACK_I,
    input  logic        ERR_I,
    input  logic        RTY_I
);

    localparam logic [15:0] TmoLast  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RetryMax = 4'(MAX_RETRY);
    // A zero gap still needs one low cycle to end the cycle on the bus.
    localparam logic [3:0]  GapLast  = (RETRY_GAP == 0) ? 4'd0 : 4'(RETRY_GAP - 1);

    typedef enum logic [1:0] {StIdle, StBus, StGap, StResp} state_e;

    state_e      state_q;
    logic [15:0] tmo_cnt_q;
    logic [3:0]  retry_cnt_q;
    logic [3:0]  gap_cnt_q;

    always_ff @(posedge CLK_I or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            tmo_cnt_q    <= 16'd0;
            retry_cnt_q  <= 4'd0;
            gap_cnt_q    <= 4'd0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_status  <= 2'b00;
            resp_data    <= 32'd0;
            CYC_O        <= 1'b0;
            STB_O        <= 1'b0;
            WE_O         <= 1'b0;
            ADR_O        <= 30'd0;
            SEL_O        <= 4'd0;
            master_DAT_O <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        WE_O         <= req_we;
                        ADR_O        <= req_adr;
                        SEL_O        <= req_sel;
                        master_DAT_O <= req_data;
                        CYC_O        <= 1'b1;
                        STB_O        <= 1'b1;
                        req_ready    <= 1'b0;
                        retry_cnt_q  <= 4'd0;
                        tmo_cnt_q    <= 16'd0;
                        state_q      <= StBus;
                    end
                end
                StBus: begin
                    if (ERR_I || ACK_I || (RTY_I && retry_cnt_q == RetryMax) ||
                        (!RTY_I && tmo_cnt_q == TmoLast)) begin
                        CYC_O      <= 1'b0;
                        STB_O      <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_data  <= 32'd0;
                        state_q    <= StResp;
                        if (ERR_I) begin
                            resp_status <= 2'b01;
                        end else if (ACK_I) begin
                            resp_status <= 2'b00;
                            if (!WE_O) resp_data <= master_DAT_I;
                        end else if (RTY_I) begin
                            resp_status <= 2'b10;
                        end else begin
                            resp_status <= 2'b11;
                        end
                    end else if (RTY_I) begin
                        retry_cnt_q <= retry_cnt_q + 4'd1;
                        CYC_O       <= 1'b0;
                        STB_O       <= 1'b0;
                        gap_cnt_q   <= 4'd0;
                        state_q     <= StGap;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        CYC_O     <= 1'b1;
                        STB_O     <= 1'b1;
                        tmo_cnt_q <= 16'd0;
                        state_q   <= StBus;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                StResp: begin
                    req_ready    <= 1'b1;
                    WE_O         <= 1'b0;
                    ADR_O        <= 30'd0;
                    SEL_O        <= 4'd0;
                    master_DAT_O <= 32'd0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
